// File: rtl/fetch_control_decode_pkg.sv
// rtl/fetch_control_decode_pkg.sv - shared widths, field slices and enums for fetch control/decode
package fetch_control_decode_pkg;

    localparam int INSN_WIDTH = 9;
    localparam int DATA_WIDTH = 8;
    localparam logic [DATA_WIDTH-1:0] START_ADDRESS = '0;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int IMM_MSB = 5;

    typedef enum logic [2:0] {
        OP_ALU_A = 3'b000,
        OP_ALU_B = 3'b001,
        OP_LOAD  = 3'b010,
        OP_STORE = 3'b011,
        OP_BR    = 3'b100,
        OP_JMP   = 3'b101,
        OP_ADDI  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        FILL,
        RUN,
        REDIRECT,
        HALTED
    } ctrl_state_t;

endpackage

// File: rtl/fetch_control_decode_if.sv
// rtl/fetch_control_decode_if.sv - fetch control and decode bus between controller, fetch and execute
interface fetch_control_decode_if;
    import fetch_control_decode_pkg::*;

    logic [INSN_WIDTH-1:0]      _instruction;
    logic                       _zeroFlag;
    logic                       fetchRun;
    logic                       fetchReset;
    logic                       fetchHalt;
    logic                       branchJump;
    logic                       relative;
    logic [DATA_WIDTH-1:0]      destBranchJump;
    logic [OPC_MSB-OPC_LSB:0]   opcode;
    logic [DATA_WIDTH-1:0]      operand;
    logic                       decodeValid;

    modport master (
        input  _instruction, _zeroFlag,
        output fetchRun, fetchReset, fetchHalt, branchJump, relative, destBranchJump,
        output opcode, operand, decodeValid
    );

    modport slave (
        output _instruction, _zeroFlag,
        input  fetchRun, fetchReset, fetchHalt, branchJump, relative, destBranchJump,
        input  opcode, operand, decodeValid
    );

endinterface

// File: rtl/fetch_control_decode_branch_target_calc.sv
// rtl/fetch_control_decode_branch_target_calc.sv - immediate extension and redirect offset for BR/JMP
module branch_target_calc
    import fetch_control_decode_pkg::*;
#(
    parameter int PC_LEAD = 2
) (
    input  logic [IMM_MSB:0]      imm,
    input  logic                  is_jmp,
    output logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH-1:0] dest
);

    // Fetch PC already sits PC_LEAD past the branch when the redirect lands.
    localparam logic [DATA_WIDTH-1:0] REL_BIAS = DATA_WIDTH'(1 - PC_LEAD);

    logic [DATA_WIDTH-1:0] sext_imm;
    logic [DATA_WIDTH-1:0] zext_imm;

    assign sext_imm = {{(DATA_WIDTH-IMM_MSB-1){imm[IMM_MSB]}}, imm};
    assign zext_imm = {{(DATA_WIDTH-IMM_MSB-1){1'b0}}, imm};

    assign operand = is_jmp ? zext_imm : sext_imm;
    assign dest    = is_jmp ? zext_imm : sext_imm + REL_BIAS;

endmodule

// File: rtl/fetch_control_decode.sv
// rtl/fetch_control_decode.sv - fetch control FSM and decode; BRANCH_COUNT_EN adds redirectCount
module fetch_control_decode
    import fetch_control_decode_pkg::*;
#(
    parameter int PC_LEAD = 2
) (
    input  logic                   _CLK,
    input  logic                   _resetN,
    input  logic                   _start,
    fetch_control_decode_if.master bus,
    output logic                   halted
`ifdef BRANCH_COUNT_EN
    ,
    output logic [15:0]            redirectCount
`endif
);

    ctrl_state_t           state;
    opcode_t               insn_op;
    logic [IMM_MSB:0]      insn_imm;
    logic                  take_redirect;
    logic [DATA_WIDTH-1:0] calc_operand;
    logic [DATA_WIDTH-1:0] calc_dest;

    assign insn_op       = opcode_t'(bus._instruction[OPC_MSB:OPC_LSB]);
    assign insn_imm      = bus._instruction[IMM_MSB:0];
    assign take_redirect = (insn_op == OP_JMP) || ((insn_op == OP_BR) && bus._zeroFlag);

    branch_target_calc #(
        .PC_LEAD (PC_LEAD)
    ) u_target (
        .imm     (insn_imm),
        .is_jmp  (insn_op == OP_JMP),
        .operand (calc_operand),
        .dest    (calc_dest)
    );

    // Outputs are registered with the state they belong to, so each arm
    // assigns the values of the state being entered.
    always_ff @(posedge _CLK) begin
        if (!_resetN) begin
            state              <= IDLE;
            bus.fetchRun       <= 1'b0;
            bus.fetchReset     <= 1'b0;
            bus.fetchHalt      <= 1'b0;
            bus.branchJump     <= 1'b0;
            bus.relative       <= 1'b0;
            bus.destBranchJump <= '0;
            bus.opcode         <= '0;
            bus.operand        <= '0;
            bus.decodeValid    <= 1'b0;
            halted             <= 1'b0;
`ifdef BRANCH_COUNT_EN
            redirectCount      <= '0;
`endif
        end else begin
            bus.fetchReset  <= 1'b0;
            bus.branchJump  <= 1'b0;
            bus.relative    <= 1'b0;
            bus.decodeValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (_start) begin
                        state          <= PRIME;
                        bus.fetchReset <= 1'b1;
                    end
                end
                PRIME: begin
                    state        <= FILL;
                    bus.fetchRun <= 1'b1;
                end
                FILL: begin
                    state <= RUN;
                end
                RUN: begin
                    // HALT is consumed here and never handed to execute.
                    if (insn_op == OP_HALT) begin
                        state         <= HALTED;
                        bus.fetchRun  <= 1'b0;
                        bus.fetchHalt <= 1'b1;
                        halted        <= 1'b1;
                    end else begin
                        bus.decodeValid <= 1'b1;
                        bus.opcode      <= insn_op;
                        bus.operand     <= calc_operand;
                        if (take_redirect) begin
                            state              <= REDIRECT;
                            bus.fetchRun       <= 1'b0;
                            bus.branchJump     <= 1'b1;
                            bus.relative       <= (insn_op == OP_BR);
                            bus.destBranchJump <= calc_dest;
`ifdef BRANCH_COUNT_EN
                            if (redirectCount != 16'hFFFF) begin
                                redirectCount <= redirectCount + 16'd1;
                            end
`endif
                        end
                    end
                end
                REDIRECT: begin
                    state        <= FILL;
                    bus.fetchRun <= 1'b1;
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
